// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU sequencer and the ALU it drives:
// opcode values, FSM state encoding and instruction word layout.
package alu_sequencer_pkg;

  // Instruction word layout
  localparam int INSTR_W = 32;
  localparam int OPC_W   = 5;
  localparam int REG_W   = 5;
  localparam int IMM_W   = 12;
  localparam int OPC_LSB = 27;
  localparam int RD_LSB  = 22;
  localparam int RS1_LSB = 17;
  localparam int RS2_LSB = 12;
  localparam int IMM_LSB = 0;

  // Opcodes
  localparam logic [OPC_W-1:0] OP_NOP   = 5'b00000;
  localparam logic [OPC_W-1:0] OP_LOAD  = 5'b00001;
  localparam logic [OPC_W-1:0] OP_STORE = 5'b00010;
  localparam logic [OPC_W-1:0] OP_ADD   = 5'b00011;
  localparam logic [OPC_W-1:0] OP_SUB   = 5'b00100;
  localparam logic [OPC_W-1:0] OP_AND   = 5'b00101;
  localparam logic [OPC_W-1:0] OP_OR    = 5'b00110;
  localparam logic [OPC_W-1:0] OP_XOR   = 5'b00111;
  localparam logic [OPC_W-1:0] OP_NOT   = 5'b01000;
  localparam logic [OPC_W-1:0] OP_SL    = 5'b01001;
  localparam logic [OPC_W-1:0] OP_SR    = 5'b01010;
  localparam logic [OPC_W-1:0] OP_JMP   = 5'b01011;
  localparam logic [OPC_W-1:0] OP_JZ    = 5'b01100;
  localparam logic [OPC_W-1:0] OP_HALT  = 5'b11111;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  typedef struct packed {
    logic [OPC_W-1:0] opcode;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [IMM_W-1:0] imm;
  } instr_t;

  // Split a raw instruction word into its fields
  function automatic instr_t unpack_instr(input logic [INSTR_W-1:0] w);
    instr_t r;
    r.opcode = w[OPC_LSB +: OPC_W];
    r.rd     = w[RD_LSB  +: REG_W];
    r.rs1    = w[RS1_LSB +: REG_W];
    r.rs2    = w[RS2_LSB +: REG_W];
    r.imm    = w[IMM_LSB +: IMM_W];
    return r;
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Bus bundle between the sequencer and its instruction memory, ALU,
// register file and data memory.
interface alu_sequencer_if
  import alu_sequencer_pkg::*;
#(
  parameter int PC_W = 8
);
  logic               imem_req;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_data;
  logic [PC_W-1:0]    pc;
  logic [OPC_W-1:0]   alu_opcode;
  logic               alu_zflag;
  logic [REG_W-1:0]   rf_raddr_a;
  logic [REG_W-1:0]   rf_raddr_b;
  logic [REG_W-1:0]   rf_waddr;
  logic               rf_we;
  logic               dmem_req;
  logic               dmem_we;
  logic               dmem_ack;
  logic [PC_W-1:0]    dmem_addr;
  logic               halted;

  modport master (
    output imem_req, pc, alu_opcode, rf_raddr_a, rf_raddr_b, rf_waddr, rf_we,
           dmem_req, dmem_we, dmem_addr, halted,
    input  imem_ack, imem_data, alu_zflag, dmem_ack
  );

  modport slave (
    input  imem_req, pc, alu_opcode, rf_raddr_a, rf_raddr_b, rf_waddr, rf_we,
           dmem_req, dmem_we, dmem_addr, halted,
    output imem_ack, imem_data, alu_zflag, dmem_ack
  );
endinterface

// File: rtl/alu_sequencer_decode.sv
// Opcode classifier; anything not listed falls through as a NOP.
module alu_sequencer_decode
  import alu_sequencer_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  output logic             is_alu,
  output logic             is_load,
  output logic             is_store,
  output logic             is_jmp,
  output logic             is_jz,
  output logic             is_halt
);

  // One-hot instruction class from the opcode
  always_comb begin
    is_alu   = 1'b0;
    is_load  = 1'b0;
    is_store = 1'b0;
    is_jmp   = 1'b0;
    is_jz    = 1'b0;
    is_halt  = 1'b0;
    case (opcode)
      OP_LOAD:  is_load  = 1'b1;
      OP_STORE: is_store = 1'b1;
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_NOT, OP_SL, OP_SR: is_alu = 1'b1;
      OP_JMP:   is_jmp   = 1'b1;
      OP_JZ:    is_jz    = 1'b1;
      OP_HALT:  is_halt  = 1'b1;
      default:  ;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle instruction sequencer: fetches a word, decodes it and steps
// the ALU, register file and data memory through FETCH/DECODE/EXEC/MEM/WB.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int PC_W = 8
)(
  input  logic              clk,
  input  logic              rst_n,
  alu_sequencer_if.master   bus
);

  state_t          state_reg, state_next;
  logic [PC_W-1:0] pc_reg, pc_next;
  instr_t          ir_reg, ir_next;
  logic            zflag_reg, zflag_next;

  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] imm_addr;
  logic            imm_unused;

  logic is_alu, is_load, is_store, is_jmp, is_jz, is_halt;

  alu_sequencer_decode u_decode (
    .opcode   (ir_reg.opcode),
    .is_alu   (is_alu),
    .is_load  (is_load),
    .is_store (is_store),
    .is_jmp   (is_jmp),
    .is_jz    (is_jz),
    .is_halt  (is_halt)
  );

  // Increment wraps naturally at the PC width
  assign pc_inc   = pc_reg + PC_W'(1);
  assign imm_addr = PC_W'(ir_reg.imm);
  // Immediate bits above the address width carry no meaning for this core
  assign imm_unused = ^ir_reg.imm;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  // Datapath registers: program counter, instruction and zero flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg    <= '0;
      ir_reg    <= '0;
      zflag_reg <= 1'b0;
    end else begin
      pc_reg    <= pc_next;
      ir_reg    <= ir_next;
      zflag_reg <= zflag_next;
    end
  end

  // Next-state and datapath update; acks are only looked at in their own state
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    ir_next    = ir_reg;
    zflag_next = zflag_reg;
    case (state_reg)
      ST_FETCH: begin
        if (bus.imem_ack) begin
          ir_next    = unpack_instr(bus.imem_data);
          state_next = ST_DECODE;
        end
      end
      ST_DECODE: state_next = ST_EXEC;
      ST_EXEC: begin
        if (is_alu) begin
          zflag_next = bus.alu_zflag;
          state_next = ST_WB;
        end else if (is_load || is_store) begin
          state_next = ST_MEM;
        end else if (is_jmp) begin
          pc_next    = imm_addr;
          state_next = ST_FETCH;
        end else if (is_jz) begin
          pc_next    = zflag_reg ? imm_addr : pc_inc;
          state_next = ST_FETCH;
        end else if (is_halt) begin
          state_next = ST_HALT;
        end else begin
          pc_next    = pc_inc;
          state_next = ST_FETCH;
        end
      end
      ST_MEM: begin
        if (bus.dmem_ack) begin
          if (is_store) begin
            pc_next    = pc_inc;
            state_next = ST_FETCH;
          end else begin
            state_next = ST_WB;
          end
        end
      end
      ST_WB: begin
        pc_next    = pc_inc;
        state_next = ST_FETCH;
      end
      ST_HALT: state_next = ST_HALT;
      default: state_next = ST_FETCH;
    endcase
  end

  // Outputs decoded from state; reset forcing the state clears them at once
  always_comb begin
    logic busy;
    busy = (state_reg == ST_EXEC) || (state_reg == ST_MEM) || (state_reg == ST_WB);

    bus.imem_req   = (state_reg == ST_FETCH);
    bus.pc         = pc_reg;
    bus.alu_opcode = (busy && (is_alu || is_load || is_store)) ? ir_reg.opcode : '0;
    bus.rf_raddr_a = (busy || state_reg == ST_DECODE) ? ir_reg.rs1 : '0;
    bus.rf_raddr_b = (busy || state_reg == ST_DECODE) ? ir_reg.rs2 : '0;
    bus.rf_waddr   = ir_reg.rd;
    bus.rf_we      = (state_reg == ST_WB);
    bus.dmem_req   = (state_reg == ST_MEM);
    bus.dmem_we    = (state_reg == ST_MEM) && is_store;
    bus.dmem_addr  = imm_addr;
    bus.halted     = (state_reg == ST_HALT);
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: hand-computed expectations per vector.
module tb_alu_sequencer;

  localparam logic [4:0] NOP   = 5'b00000;
  localparam logic [4:0] LOAD  = 5'b00001;
  localparam logic [4:0] STORE = 5'b00010;
  localparam logic [4:0] ADD   = 5'b00011;
  localparam logic [4:0] SUB   = 5'b00100;
  localparam logic [4:0] JMP   = 5'b01011;
  localparam logic [4:0] JZ    = 5'b01100;
  localparam logic [4:0] HALT  = 5'b11111;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   bad;

  alu_sequencer_if #(.PC_W(8)) bus ();

  alu_sequencer #(.PC_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expected);
    n_checks++;
    if (got === expected) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expected);
  endtask

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2,
                                     input logic [11:0] imm);
    return {op, rd, rs1, rs2, imm};
  endfunction

  // Wait (bounded) for a fetch request, hand over the word in one cycle.
  // Returns at the falling edge where the DUT sits in DECODE.
  task automatic issue(input string name, input logic [31:0] instr);
    int waited = 0;
    while (bus.imem_req !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check({name, "_fetch_req"}, {31'd0, bus.imem_req}, 32'd1);
    $display("txn %s pc=0x%02h instr=0x%08h", name, bus.pc, instr);
    bus.imem_ack  = 1'b1;
    bus.imem_data = instr;
    @(negedge clk);
    bus.imem_ack  = 1'b0;
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.imem_ack  = 1'b0;
    bus.imem_data = '0;
    bus.alu_zflag = 1'b0;
    bus.dmem_ack  = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_pc", {24'd0, bus.pc}, 32'd0);
    check("rst_ctl", {28'd0, bus.halted, bus.rf_we, bus.dmem_req, bus.dmem_we}, 32'd0);
    check("rst_aluop", {27'd0, bus.alu_opcode}, 32'd0);
    rst_n = 1'b1;

    // ADD rd=3 with ack in the first FETCH cycle
    issue("add", mk(ADD, 5'd3, 5'd1, 5'd2, 12'h0));
    check("add_dec_raddr", {22'd0, bus.rf_raddr_a, bus.rf_raddr_b}, {22'd0, 5'd1, 5'd2});
    check("add_dec_aluop", {27'd0, bus.alu_opcode}, 32'd0);
    @(negedge clk);
    check("add_exec", {26'd0, bus.rf_we, bus.alu_opcode}, {26'd0, 1'b0, 5'd3});
    @(negedge clk);
    check("add_wb", {21'd0, bus.rf_we, bus.rf_waddr, bus.alu_opcode}, {21'd0, 1'b1, 5'd3, 5'd3});
    @(negedge clk);
    check("add_next", {23'd0, bus.rf_we, bus.pc}, {23'd0, 1'b0, 8'h01});

    // SUB setting zero, then JZ taken
    issue("sub_z1", mk(SUB, 5'd1, 5'd1, 5'd1, 12'h0));
    @(negedge clk);
    bus.alu_zflag = 1'b1;
    check("sub_exec_aluop", {27'd0, bus.alu_opcode}, {27'd0, SUB});
    @(negedge clk);
    bus.alu_zflag = 1'b0;
    @(negedge clk);
    check("sub_pc", {24'd0, bus.pc}, 32'h02);
    issue("jz_taken", mk(JZ, 5'd0, 5'd0, 5'd0, 12'h040));
    @(negedge clk);
    check("jz_exec_aluop", {27'd0, bus.alu_opcode}, 32'd0);
    @(negedge clk);
    check("jz_taken_pc", {24'd0, bus.pc}, 32'h40);

    // SUB clearing zero (stray fetch ack must not disturb it), JZ not taken
    issue("sub_z0", mk(SUB, 5'd2, 5'd3, 5'd4, 12'h0));
    bus.imem_ack  = 1'b1;
    bus.imem_data = mk(HALT, 5'd0, 5'd0, 5'd0, 12'h0);
    @(negedge clk);
    bus.imem_ack  = 1'b0;
    check("sub_stray_ack", {27'd0, bus.alu_opcode}, {27'd0, SUB});
    @(negedge clk);
    @(negedge clk);
    check("sub2_pc", {24'd0, bus.pc}, 32'h41);
    issue("jz_not", mk(JZ, 5'd0, 5'd0, 5'd0, 12'h040));
    @(negedge clk);
    bus.alu_zflag = 1'b1;
    @(negedge clk);
    bus.alu_zflag = 1'b0;
    check("jz_not_pc", {24'd0, bus.pc}, 32'h42);

    // STORE with ack after three wait cycles
    issue("store", mk(STORE, 5'd0, 5'd5, 5'd6, 12'h010));
    bus.dmem_ack = 1'b1;
    @(negedge clk);
    bus.dmem_ack = 1'b0;
    check("store_exec", {26'd0, bus.dmem_req, bus.alu_opcode}, {26'd0, 1'b0, STORE});
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check("store_mem", {21'd0, bus.dmem_req, bus.dmem_we, bus.rf_we, bus.dmem_addr},
            {21'd0, 1'b1, 1'b1, 1'b0, 8'h10});
      if (k == 3) bus.dmem_ack = 1'b1;
      @(negedge clk);
    end
    bus.dmem_ack = 1'b0;
    check("store_done", {22'd0, bus.dmem_req, bus.rf_we, bus.pc}, {22'd0, 1'b0, 1'b0, 8'h43});

    // LOAD rd=7 with immediate ack
    issue("load", mk(LOAD, 5'd7, 5'd0, 5'd0, 12'h020));
    @(negedge clk);
    @(negedge clk);
    check("load_mem", {17'd0, bus.dmem_req, bus.dmem_we, bus.dmem_addr, bus.alu_opcode},
          {17'd0, 1'b1, 1'b0, 8'h20, LOAD});
    bus.dmem_ack = 1'b1;
    @(negedge clk);
    bus.dmem_ack = 1'b0;
    check("load_wb", {25'd0, bus.rf_we, bus.rf_waddr, bus.dmem_req}, {25'd0, 1'b1, 5'd7, 1'b0});
    @(negedge clk);
    check("load_pc", {24'd0, bus.pc}, 32'h44);

    // JMP to 0xFF, NOP wraps to 0, illegal opcode acts as NOP
    issue("jmp", mk(JMP, 5'd0, 5'd0, 5'd0, 12'h0FF));
    @(negedge clk);
    @(negedge clk);
    check("jmp_pc", {24'd0, bus.pc}, 32'hFF);
    issue("nop_wrap", mk(NOP, 5'd0, 5'd0, 5'd0, 12'h0));
    @(negedge clk);
    check("nop_exec", {30'd0, bus.rf_we, bus.dmem_req}, 32'd0);
    @(negedge clk);
    check("nop_wrap_pc", {24'd0, bus.pc}, 32'h00);
    issue("illegal", mk(5'b10101, 5'd9, 5'd0, 5'd0, 12'h0));
    @(negedge clk);
    check("illegal_exec", {25'd0, bus.rf_we, bus.dmem_req, bus.alu_opcode}, 32'd0);
    @(negedge clk);
    check("illegal_pc", {24'd0, bus.pc}, 32'h01);

    // HALT holds through toggling fetch acks; reset releases it
    issue("halt", mk(HALT, 5'd0, 5'd0, 5'd0, 12'h0));
    @(negedge clk);
    @(negedge clk);
    check("halted", {31'd0, bus.halted}, 32'd1);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      bus.imem_ack  = i[0];
      bus.imem_data = mk(ADD, 5'd1, 5'd0, 5'd0, 12'h0);
      @(negedge clk);
      if (bus.imem_req !== 1'b0 || bus.pc !== 8'h01 || bus.halted !== 1'b1) bad++;
    end
    bus.imem_ack = 1'b0;
    check("halt_hold_bad_cycles", bad, 32'd0);
    rst_n = 1'b0;
    #1;
    check("halt_rst", {23'd0, bus.halted, bus.pc}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check("halt_rst_fetch", {23'd0, bus.imem_req, bus.pc}, {23'd0, 1'b1, 8'h00});

    // Reset pulsed while waiting in MEM aborts the access
    issue("nop", mk(NOP, 5'd0, 5'd0, 5'd0, 12'h0));
    @(negedge clk);
    @(negedge clk);
    check("nop_pc", {24'd0, bus.pc}, 32'h01);
    issue("store_abort", mk(STORE, 5'd0, 5'd0, 5'd0, 12'h033));
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("abort_mem_wait", {31'd0, bus.dmem_req}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_drop", {21'd0, bus.dmem_req, bus.dmem_we, bus.imem_req, bus.pc},
          {21'd0, 1'b0, 1'b0, 1'b1, 8'h00});
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_fetch", {23'd0, bus.imem_req, bus.pc}, {23'd0, 1'b1, 8'h00});
    issue("post_abort_add", mk(ADD, 5'd4, 5'd0, 5'd0, 12'h0));
    @(negedge clk);
    @(negedge clk);
    check("post_abort_wb", {26'd0, bus.rf_we, bus.rf_waddr}, {26'd0, 1'b1, 5'd4});
    @(negedge clk);
    check("post_abort_pc", {24'd0, bus.pc}, 32'h01);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
